// File: rtl/logic_gates_pipelined_unit.sv
// Two-stage valid/ready pipeline computing bitwise logic ops on a and b,
// with zero/parity flags registered alongside the result and a saturating output counter.
module logic_gates_pipelined_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_NOTA = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    logic             s1_vld_q, s2_vld_q;
    logic [WIDTH-1:0] a_q, b_q;
    op_e              op_q;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, parity_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s2_adv, out_xfer;

    // S2 can take new data when empty or draining this cycle; S1 follows S2.
    assign s2_adv   = !s2_vld_q || out_ready;
    assign in_ready = rst_n && (!s1_vld_q || s2_adv);
    assign out_xfer = s2_vld_q && out_ready;

    always_comb begin
        y_d = '0;
        case (op_q)
            OP_AND:  y_d = a_q & b_q;
            OP_NAND: y_d = ~(a_q & b_q);
            OP_OR:   y_d = a_q | b_q;
            OP_NOR:  y_d = ~(a_q | b_q);
            OP_NOTA: y_d = ~a_q;
            OP_XOR:  y_d = a_q ^ b_q;
            OP_XNOR: y_d = ~(a_q ^ b_q);
            OP_PASS: y_d = b_q;
            default: y_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            y_q      <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (in_ready) begin
                s1_vld_q <= in_valid;
                if (in_valid) begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op_e'(op);
                end
            end
            if (s2_adv) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    y_q      <= y_d;
                    zero_q   <= (y_d == '0);
                    parity_q <= ^y_d;
                end
            end
            if (out_xfer && !(&cnt_q))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = s2_vld_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_gates_pipelined_unit.sv
// Scoreboard bench: the driver pushes expected results on accept, the monitor
// pops and compares on every output transfer; also checks in_ready, hold and counters.
module tb_logic_gates_pipelined_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [2:0] op = '0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, zero, parity;
    logic [7:0] y;
    logic [15:0] op_count;
    logic       in_ready4, out_valid4, zero4, parity4;
    logic [7:0] y4;
    logic [3:0] op_count4;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt = 0;
    int ordy_mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random
    logic [7:0] q[$];

    always #5 clk = ~clk;

    logic_gates_pipelined_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .parity(parity), .op_count(op_count));

    logic_gates_pipelined_unit #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
        .y(y4), .zero(zero4), .parity(parity4), .op_count(op_count4));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
        case (mop)
            3'd0: return ma & mb;
            3'd1: return ~(ma & mb);
            3'd2: return ma | mb;
            3'd3: return ~(ma | mb);
            3'd4: return ~ma;
            3'd5: return ma ^ mb;
            3'd6: return ~(ma ^ mb);
            default: return mb;
        endcase
    endfunction

    task automatic drive_ordy();
        case (ordy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Offer one operand set until accepted; returns the number of stalled cycles.
    task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic [2:0] sop,
                        input logic [7:0] expy, output int waits);
        waits = 0;
        forever begin
            @(negedge clk);
            in_valid = 1'b1; a = sa; b = sb; op = sop;
            drive_ordy();
            #2;
            if (in_ready) begin
                q.push_back(expy);
                break;
            end
            waits++;
            if (waits > 200) begin
                chk("send_timeout", 64'(waits), 0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            drive_ordy();
        end
    endtask

    task automatic drain();
        int guard = 0;
        ordy_mode = 0;
        while (q.size() != 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        chk("drain_empty", 64'(q.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #2;
        q.delete();
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_y", 64'(y), 0);
        chk("rst_zero", 64'(zero), 1);
        chk("rst_parity", 64'(parity), 0);
        chk("rst_op_count", 64'(op_count), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
    endtask

    // Monitor: all inputs change only at negedge, so values seen at negedge+1
    // are exactly what the next rising edge will sample.
    logic       hold_prev = 1'b0;
    logic [7:0] prev_y;
    logic       prev_z, prev_p;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            chk("in_ready_in_reset", 64'(in_ready), 0);
            hold_prev = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
            chk("op_count", 64'(op_count), 64'(cnt));
            chk("op_count_sat4", 64'(op_count4), 64'((cnt > 15) ? 15 : cnt));
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid), 1);
                chk("hold_y", 64'({y, zero, parity}), 64'({prev_y, prev_z, prev_p}));
            end
            if (q.size() == 0) begin
                chk("no_spurious_out", 64'(out_valid), 0);
            end else if (out_valid) begin
                chk("y", 64'(y), 64'(q[0]));
                chk("zero", 64'(zero), 64'(q[0] == 8'h00));
                chk("parity", 64'(parity), 64'(^q[0]));
                if (out_ready) begin
                    void'(q.pop_front());
                    cnt++;
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_y = y; prev_z = zero; prev_p = parity;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [7:0] ra, rb;
        logic [2:0] rop;
        logic [7:0] exp32 [8];
        exp32[0] = 8'h30; exp32[1] = 8'hCF; exp32[2] = 8'hFC; exp32[3] = 8'h03;
        exp32[4] = 8'h0F; exp32[5] = 8'hCC; exp32[6] = 8'h33; exp32[7] = 8'h3C;

        do_reset();

        // Latency: a single accept shows up two cycles later.
        ordy_mode = 0;
        send(8'hF0, 8'h3C, 3'd0, 8'h30, w);
        @(negedge clk); in_valid = 1'b0; #3;
        chk("latency_c1", 64'(out_valid), 0);
        @(negedge clk); #3;
        chk("latency_c2", 64'(out_valid), 1);
        drain();

        // All eight ops back-to-back at full throughput.
        for (int i = 0; i < 8; i++) begin
            send(8'hF0, 8'h3C, 3'(i), exp32[i], w);
            chk("throughput_no_stall", 64'(w), 0);
        end
        drain();

        // Flag corner cases.
        send(8'h55, 8'hAA, 3'd0, 8'h00, w);
        send(8'h55, 8'hAA, 3'd2, 8'hFF, w);
        send(8'h01, 8'h01, 3'd7, 8'h01, w);
        drain();

        // Backpressure: two accepts fill the pipe, third waits for space.
        ordy_mode = 1;
        send(8'h12, 8'h34, 3'd5, 8'h26, w);
        send(8'hA5, 8'h0F, 3'd0, 8'h05, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h80; b = 8'h01; op = 3'd2; out_ready = 1'b0;
            #2;
            chk("full_in_ready", 64'(in_ready), 0);
        end
        ordy_mode = 0;
        send(8'h80, 8'h01, 3'd2, 8'h81, w);
        drain();

        // Random handshakes with gaps; exercises counter saturation on dut4.
        ordy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
            send(ra, rb, rop, model(ra, rb, rop), w);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // Reset with two results in flight: both must vanish.
        send(8'hFF, 8'h0F, 3'd0, 8'h0F, w);
        send(8'hFF, 8'h0F, 3'd5, 8'hF0, w);
        do_reset();
        ordy_mode = 0;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
